// File: rtl/adsr_gate_pkg.sv
// Shared types for the ADSR gate controller: FSM states, stack ops, stack entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adsr_gate_pkg;

   localparam int NOTE_W = 7;
   localparam int VEL_W  = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_RETRIG = 2'd2
   } state_e;

   typedef enum logic {
      OP_PUSH   = 1'b0,
      OP_REMOVE = 1'b1
   } stack_op_e;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [VEL_W-1:0]  vel;
   } entry_t;

endpackage

// File: rtl/note_stack.sv
// Last-note-priority stack of held {note, vel}; index 0 is the newest (top) entry.
// Latency: search/remove/compact/push all land on the single edge where en is high.
// Backpressure: none; accepts one op per enabled cycle, full stack drops its oldest entry.
module note_stack
   import adsr_gate_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  stack_op_e         op,
   input  logic [NOTE_W-1:0] key,
   input  entry_t            entry,
   output entry_t            top,
   output logic [CW-1:0]     count,
   output entry_t            nxt_top,
   output logic              nxt_empty
);

   entry_t        stk [DEPTH];
   entry_t        ext [DEPTH+1];
   entry_t        rm  [DEPTH];
   entry_t        nxt [DEPTH];
   logic [CW-1:0] cnt;
   logic [CW-1:0] rm_cnt;
   logic [CW-1:0] nxt_cnt;
   logic          hit;
   int            pos;

   // Parallel search for key, compaction over the hit slot, then optional push on top.
   always_comb begin
      hit = 1'b0;
      pos = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
         if (!hit && (i < int'(cnt)) && (stk[i].note == key)) begin
            hit = 1'b1;
            pos = i;
         end
      end
      for (int i = 0; i < DEPTH; i++) ext[i] = stk[i];
      ext[DEPTH] = '0;
      for (int i = 0; i < DEPTH; i++) rm[i] = (i >= pos) ? ext[i+1] : ext[i];
      rm_cnt = hit ? (cnt - CW'(1)) : cnt;

      if (op == OP_PUSH) begin
         nxt[0] = entry;
         for (int i = 1; i < DEPTH; i++) nxt[i] = rm[i-1];
         nxt_cnt = (rm_cnt == CW'(DEPTH)) ? rm_cnt : (rm_cnt + CW'(1));
      end else begin
         for (int i = 0; i < DEPTH; i++) nxt[i] = rm[i];
         nxt_cnt = rm_cnt;
      end
   end

   // Stack storage: committed only on enabled cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      end else if (en) begin
         cnt <= nxt_cnt;
         for (int i = 0; i < DEPTH; i++) stk[i] <= nxt[i];
      end
   end

   assign top       = stk[0];
   assign count     = cnt;
   assign nxt_top   = nxt[0];
   assign nxt_empty = (nxt_cnt == '0);

endmodule

// File: rtl/adsr_gate_ctrl.sv
// Turns note-on/off events into GATE/note/vel for one adsr32 voice with legato fallback.
// Latency: outputs move one edge after the handshake edge; retrigger adds RETRIG_CYC gate-low cycles.
// Backpressure: ev_ready only in IDLE, so at most one event per 2 (or RETRIG_CYC+2) cycles.
module adsr_gate_ctrl
   import adsr_gate_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int RETRIG_CYC = 4,
   parameter int CNT_W      = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ev_valid,
   output logic                       ev_ready,
   input  logic                       ev_on,
   input  logic [NOTE_W-1:0]          ev_note,
   input  logic [VEL_W-1:0]           ev_vel,
   output logic                       GATE,
   output logic [NOTE_W-1:0]          note,
   output logic [VEL_W-1:0]           vel,
   output logic [$clog2(DEPTH+1)-1:0] held
);

   localparam logic [CNT_W-1:0] RELOAD = (RETRIG_CYC > 0) ? CNT_W'(RETRIG_CYC - 1) : '0;

   state_e            state, nxt_state;
   logic [CNT_W-1:0]  cnt, nxt_cnt;
   logic              nxt_gate;
   logic [NOTE_W-1:0] nxt_note;
   logic [VEL_W-1:0]  nxt_vel;
   logic              on_q;
   logic [NOTE_W-1:0] key_q;
   logic [VEL_W-1:0]  kvel_q;
   entry_t            push_ent;
   entry_t            stk_top;
   entry_t            stk_nxt_top;
   logic              stk_nxt_empty;

   assign ev_ready = (state == ST_IDLE) && !rst;
   assign push_ent = '{note: key_q, vel: kvel_q};

   // Capture the accepted event; velocity-0 note-on is folded into a note-off here.
   always_ff @(posedge clk) begin
      if (rst) begin
         on_q   <= 1'b0;
         key_q  <= '0;
         kvel_q <= '0;
      end else if (ev_valid && ev_ready) begin
         on_q   <= ev_on && (ev_vel != '0);
         key_q  <= ev_note;
         kvel_q <= ev_vel;
      end
   end

   note_stack #(.DEPTH(DEPTH)) u_stack (
      .clk       (clk),
      .rst       (rst),
      .en        (state == ST_UPDATE),
      .op        (on_q ? OP_PUSH : OP_REMOVE),
      .key       (key_q),
      .entry     (push_ent),
      .top       (stk_top),
      .count     (held),
      .nxt_top   (stk_nxt_top),
      .nxt_empty (stk_nxt_empty)
   );

   // Next-state and next-output decisions for the event/retrigger FSM.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_gate  = GATE;
      nxt_note  = note;
      nxt_vel   = vel;
      unique case (state)
         ST_IDLE: begin
            if (ev_valid && ev_ready) nxt_state = ST_UPDATE;
         end
         ST_UPDATE: begin
            nxt_state = ST_IDLE;
            if (on_q) begin
               if (!GATE) begin
                  nxt_gate = 1'b1;
                  nxt_note = key_q;
                  nxt_vel  = kvel_q;
               end else if (RETRIG_CYC > 0) begin
                  // Pitch change is deferred to the end of the gap so the release tail keeps the old note.
                  nxt_gate  = 1'b0;
                  nxt_cnt   = RELOAD;
                  nxt_state = ST_RETRIG;
               end else begin
                  nxt_note = key_q;
                  nxt_vel  = kvel_q;
               end
            end else if (stk_nxt_empty) begin
               nxt_gate = 1'b0;
            end else begin
               // While sounding, note/vel always mirror the stack top, so taking the new top
               // covers both the legato fallback and the unchanged non-top removal.
               nxt_note = stk_nxt_top.note;
               nxt_vel  = stk_nxt_top.vel;
            end
         end
         ST_RETRIG: begin
            if (cnt == '0) begin
               nxt_gate  = 1'b1;
               nxt_note  = stk_top.note;
               nxt_vel   = stk_top.vel;
               nxt_state = ST_IDLE;
            end else begin
               nxt_cnt = cnt - CNT_W'(1);
            end
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   // State, retrigger counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         GATE  <= 1'b0;
         note  <= '0;
         vel   <= '0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         GATE  <= nxt_gate;
         note  <= nxt_note;
         vel   <= nxt_vel;
      end
   end

endmodule
